// File: rtl/systolic_job_arbiter_pkg.sv
// Shared state codes and field-width helpers for the systolic job arbiter.
// State codes are plain constants so older tools can consume them.
package systolic_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_RUN     = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  function automatic int cw(input int size);
    return $clog2(size) + 2;
  endfunction

  function automatic int ww(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/systolic_job_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ...
// modulo NREQ. Kept generic so other arbiters can reuse it.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   index
);

  // Scan from the farthest offset back to ptr so the closest hit wins.
  always_comb begin
    logic [IW:0] pos;
    valid = 1'b0;
    index = '0;
    pos   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(NREQ)) begin
        pos = pos - (IW + 1)'(NREQ);
      end
      if (req[pos[IW-1:0]]) begin
        valid = 1'b1;
        index = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Round-robin arbiter sharing one systolic array controller among NREQ requesters.
// Optional RUN watchdog enabled by defining ARB_TIMEOUT_EN.
module systolic_job_arbiter
  import systolic_arb_pkg::*;
#(
  parameter int SIZE           = 16,
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CW = cw(SIZE),
  localparam int WW = ww(SIZE),
  localparam int IW = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*CW-1:0] req_cycles,
  input  logic [NREQ*WW-1:0] req_width_A,
  input  logic [NREQ*WW-1:0] req_width_B,
  output logic [NREQ-1:0]  ack,
  output logic [NREQ-1:0]  grant,
  output logic [NREQ-1:0]  req_done,
  output logic [IW-1:0]    owner,
  output logic             arr_start,
  output logic [CW-1:0]    arr_cycles_in,
  output logic [WW-1:0]    arr_width_A,
  output logic [WW-1:0]    arr_width_B,
  input  logic             arr_busy,
  input  logic             arr_done,
  output logic             idle,
  output logic             timeout_err
);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d, pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] ack_q, ack_d, grant_q, grant_d, done_q, done_d;
  logic            start_q, start_d, idle_q, idle_d;
  logic [CW-1:0]   cyc_q, cyc_d, sel_cyc;
  logic [WW-1:0]   wa_q, wa_d, sel_wa, wb_q, wb_d, sel_wb;
  logic            tmo_hit;

  // arr_busy is informational only; transitions never depend on it.
  logic unused_busy;
  assign unused_busy = arr_busy;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    sel_cyc = '0;
    sel_wa  = '0;
    sel_wb  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_cyc = req_cycles[i*CW +: CW];
        sel_wa  = req_width_A[i*WW +: WW];
        sel_wb  = req_width_B[i*WW +: WW];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo_q;

  // The counter holds zero outside RUN, so it is fresh on every RUN entry.
  assign cnt_d   = (state_q == ST_RUN) ? cnt_q + TW'(1) : '0;
  assign tmo_hit = (state_q == ST_RUN) && !arr_done
                   && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_hit;
    end
  end

  assign timeout_err = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ack_d   = '0;
    grant_d = grant_q;
    done_d  = '0;
    start_d = 1'b0;
    cyc_d   = cyc_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cyc_d   = sel_cyc;
          wa_d    = sel_wa;
          wb_d    = sel_wb;
          grant_d = NREQ'(1) << pick_idx;
          ack_d   = NREQ'(1) << pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (arr_done || tmo_hit) begin
          done_d  = NREQ'(1) << owner_q;
          grant_d = '0;
          ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
          state_d = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      cyc_q   <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      start_q <= start_d;
      cyc_q   <= cyc_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      idle_q  <= idle_d;
    end
  end

  assign ack           = ack_q;
  assign grant         = grant_q;
  assign req_done      = done_q;
  assign owner         = owner_q;
  assign arr_start     = start_q;
  assign arr_cycles_in = cyc_q;
  assign arr_width_A   = wa_q;
  assign arr_width_B   = wb_q;
  assign idle          = idle_q;

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Testbench for systolic_job_arbiter: directed job-level checks plus a randomized
// run compared every cycle against a job-level reference model.
module tb_systolic_job_arbiter;

  localparam int SIZE = 16;
  localparam int NREQ = 4;
  localparam int CW   = 6;
  localparam int WW   = 5;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] req_cycles;
  logic [NREQ*WW-1:0] req_width_A, req_width_B;
  logic [NREQ-1:0]   ack, grant, req_done;
  logic [1:0]        owner;
  logic              arr_start, arr_busy, arr_done, idle, timeout_err;
  logic [CW-1:0]     arr_cycles_in;
  logic [WW-1:0]     arr_width_A, arr_width_B;

  int checks   = 0;
  int failures = 0;

  systolic_job_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_cycles    (req_cycles),
    .req_width_A   (req_width_A),
    .req_width_B   (req_width_B),
    .ack           (ack),
    .grant         (grant),
    .req_done      (req_done),
    .owner         (owner),
    .arr_start     (arr_start),
    .arr_cycles_in (arr_cycles_in),
    .arr_width_A   (arr_width_A),
    .arr_width_B   (arr_width_B),
    .arr_busy      (arr_busy),
    .arr_done      (arr_done),
    .idle          (idle),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level reference model: a phase per job (0 wait, 1 issue, 2 run, 3 release).
  int          mPhase = 0, mPtr = 0, mOwner = 0, mRun = 0;
  bit          mValid = 0;
  logic [3:0]  eAck = '0, eGrant = '0, eDone = '0;
  logic [1:0]  eOwner = '0;
  logic        eStart = 0, eIdle = 1, eTmo = 0;
  logic [CW-1:0] eCyc = '0;
  logic [WW-1:0] eWa = '0, eWb = '0;

  always @(posedge clk) begin
    bit finish;
    int w;
    finish = 0;
    w = -1;
    if (reset) begin
      mValid = 1;
      mPhase = 0; mPtr = 0; mOwner = 0;
      eAck = '0; eGrant = '0; eDone = '0; eOwner = '0;
      eStart = 0; eTmo = 0; eCyc = '0; eWa = '0; eWb = '0;
    end else begin
      eAck = '0; eDone = '0; eStart = 0; eTmo = 0;
      case (mPhase)
        0: begin
          for (int k = 0; k < NREQ; k++) begin
            if (w < 0 && ((req >> ((mPtr + k) % NREQ)) & 4'd1) != 4'd0) w = (mPtr + k) % NREQ;
          end
          if (w >= 0) begin
            mOwner = w;
            eOwner = 2'(w);
            eCyc   = CW'(req_cycles >> (w * CW));
            eWa    = WW'(req_width_A >> (w * WW));
            eWb    = WW'(req_width_B >> (w * WW));
            eAck   = 4'(1 << w);
            eGrant = 4'(1 << w);
            mPhase = 1;
          end
        end
        1: begin
          eStart = 1;
          mRun   = 0;
          mPhase = 2;
        end
        2: begin
          mRun++;
          if (arr_done) finish = 1;
`ifdef ARB_TIMEOUT_EN
          else if (mRun == TMO) begin
            finish = 1;
            eTmo   = 1;
          end
`endif
          if (finish) begin
            eDone  = 4'(1 << mOwner);
            eGrant = '0;
            mPtr   = (mOwner + 1) % NREQ;
            mPhase = 3;
          end
        end
        default: mPhase = 0;
      endcase
    end
    eIdle = (mPhase == 0);
  end

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("ack", 32'(ack), 32'(eAck));
      checkOutput("grant", 32'(grant), 32'(eGrant));
      checkOutput("req_done", 32'(req_done), 32'(eDone));
      checkOutput("owner", 32'(owner), 32'(eOwner));
      checkOutput("arr_start", 32'(arr_start), 32'(eStart));
      checkOutput("arr_cycles_in", 32'(arr_cycles_in), 32'(eCyc));
      checkOutput("arr_width_A", 32'(arr_width_A), 32'(eWa));
      checkOutput("arr_width_B", 32'(arr_width_B), 32'(eWb));
      checkOutput("idle", 32'(idle), 32'(eIdle));
      checkOutput("timeout_err", 32'(timeout_err), 32'(eTmo));
    end
  end

  // Array controller responder and stray-done generator, all driven from one process.
  bit autoCtl = 0, strayEn = 0;
  int ctlCount = 0;

  task automatic applyStimulus();
    @(negedge clk);
    if (reset) ctlCount = 0;
    if (autoCtl) begin
      arr_done = 1'b0;
      if (ctlCount > 0) begin
        ctlCount--;
        if (ctlCount == 0) arr_done = 1'b1;
      end
      if (arr_start) ctlCount = $urandom_range(1, 8);
      if (strayEn && $urandom_range(0, 19) == 0) arr_done = 1'b1;
    end
  endtask

  task automatic setField(input int i, input int c, input int a, input int b);
    req_cycles  = (req_cycles  & ~(24'h3f << (i * CW))) | (24'(c & 'h3f) << (i * CW));
    req_width_A = (req_width_A & ~(20'h1f << (i * WW))) | (20'(a & 'h1f) << (i * WW));
    req_width_B = (req_width_B & ~(20'h1f << (i * WW))) | (20'(b & 'h1f) << (i * WW));
  endtask

  function automatic int idxOf(input logic [3:0] v);
    for (int k = 0; k < NREQ; k++) if (((v >> k) & 4'd1) != 4'd0) return k;
    return -1;
  endfunction

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!idle && n < 60) begin
      applyStimulus();
      n++;
    end
    checkOutput(name, 32'(idle), 1);
  endtask

  initial begin
    int n;
    reset = 1'b1; req = '0; arr_done = 1'b0; arr_busy = 1'b0;
    req_cycles = '0; req_width_A = '0; req_width_B = '0;
    repeat (3) applyStimulus();
    checkOutput("rst_idle", 32'(idle), 1);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_cycles", 32'(arr_cycles_in), 0);
    reset = 1'b0;

    // Stray done while idle must be ignored.
    arr_done = 1'b1;
    applyStimulus();
    arr_done = 1'b0;
    checkOutput("stray_idle_done", 32'(req_done), 0);
    checkOutput("stray_idle_idle", 32'(idle), 1);

    // Single job from requester 1, with a stray done during ISSUE.
    setField(1, 5, 3, 4);
    req = 4'b0010;
    applyStimulus();
    checkOutput("job_ack", 32'(ack), 'h2);
    checkOutput("pin_model_ack", 32'(eAck), 'h2);
    checkOutput("job_grant", 32'(grant), 'h2);
    req = '0;
    setField(1, 9, 7, 8);
    arr_done = 1'b1;
    applyStimulus();
    arr_done = 1'b0;
    checkOutput("job_start", 32'(arr_start), 1);
    checkOutput("job_cycles", 32'(arr_cycles_in), 5);
    checkOutput("job_wA", 32'(arr_width_A), 3);
    checkOutput("job_wB", 32'(arr_width_B), 4);
    checkOutput("pin_model_cycles", 32'(eCyc), 5);
    checkOutput("stray_issue_done", 32'(req_done), 0);
    applyStimulus();
    checkOutput("start_pulse_end", 32'(arr_start), 0);
    repeat (18) applyStimulus();
    checkOutput("capture_hold", 32'(arr_cycles_in), 5);
    checkOutput("run_grant", 32'(grant), 'h2);
    arr_done = 1'b1;
    applyStimulus();
    arr_done = 1'b0;
    checkOutput("job_done", 32'(req_done), 'h2);
    checkOutput("pin_model_done", 32'(eDone), 'h2);
    checkOutput("job_grant_clear", 32'(grant), 0);
    checkOutput("release_not_idle", 32'(idle), 0);
    applyStimulus();
    checkOutput("job_idle", 32'(idle), 1);
    checkOutput("done_pulse_end", 32'(req_done), 0);

    // Round robin with all requesters held high from pointer 0.
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    autoCtl = 1;
    req_cycles = 24'($urandom); req_width_A = 20'($urandom); req_width_B = 20'($urandom);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        applyStimulus();
        n++;
      end while (ack == '0 && n < 40);
      checkOutput("rr_order", 32'(idxOf(ack)), 32'(g % NREQ));
    end
    req = '0;
    waitIdle("rr_drain_idle");

    // Reset in the middle of a running job, then a normal grant to requester 3.
    autoCtl = 0;
    setField(2, 12, 6, 6);
    req = 4'b0100;
    applyStimulus();
    req = '0;
    repeat (11) applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midrst_grant", 32'(grant), 0);
    checkOutput("midrst_idle", 32'(idle), 1);
    checkOutput("midrst_owner", 32'(owner), 0);
    checkOutput("midrst_cycles", 32'(arr_cycles_in), 0);
    req = 4'b1000;
    applyStimulus();
    checkOutput("post_rst_ack", 32'(ack), 'h8);
    checkOutput("post_rst_owner", 32'(owner), 3);
    req = '0;
    autoCtl = 1;
    waitIdle("post_rst_idle");

`ifdef ARB_TIMEOUT_EN
    // No done from the controller: the watchdog must close the job.
    autoCtl = 0;
    req = 4'b0001;
    n = 0;
    do begin
      applyStimulus();
      if (ack != '0) req = '0;
      n++;
    end while (!timeout_err && n < 40);
    checkOutput("tmo_seen", 32'(timeout_err), 1);
    checkOutput("tmo_done", 32'(req_done), 'h1);
    autoCtl = 1;
    waitIdle("tmo_idle");
`endif

    // Randomized traffic with strays and occasional resets.
    strayEn = 1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        req_cycles = 24'($urandom); req_width_A = 20'($urandom); req_width_B = 20'($urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_job_arbiter.md
Name: systolic_job_arbiter

Overview:
- Shares one systolic array and its control FSM among NREQ requesters (host DMA, accelerator cores).
- Accepts one matrix-multiply job per grant: cycles, width_A, width_B.
- Forwards the job to the array controller, pulses start, waits for the controller's done pulse, then returns a per-requester completion pulse.
- Round-robin fairness; only one job in flight.

Parameters:
- SIZE, 16: systolic array dimension. Sets field widths CW = $clog2(SIZE)+2 (cycles) and WW = $clog2(SIZE)+1 (widths).
- NREQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 1024: watchdog limit. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester job request, level, held until ack
- req_cycles  in  NREQ*CW  packed per-requester cycle count; requester i uses bits [i*CW +: CW]
- req_width_A  in  NREQ*WW  packed per-requester A row width
- req_width_B  in  NREQ*WW  packed per-requester B row width
- ack  out  NREQ  one-cycle pulse: job accepted, parameters captured
- grant  out  NREQ  one-hot; high from ack until completion
- req_done  out  NREQ  one-cycle completion pulse to owner
- owner  out  $clog2(NREQ)  index of current/last owner
- arr_start  out  1  start pulse to array controller
- arr_cycles_in  out  CW  captured cycles
- arr_width_A  out  WW  captured A width
- arr_width_B  out  WW  captured B width
- arr_busy  in  1  controller busy
- arr_done  in  1  controller done pulse
- idle  out  1  high in IDLE
- timeout_err  out  1  watchdog pulse (ARB_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous, active-high.
- Reset values, also applied on reset mid-job: state=IDLE; ptr=0; owner=0; ack, grant, req_done, arr_start, timeout_err = 0; arr_* parameter outputs = 0; idle=1. The array controller shares reset, so there is no drain.
- All outputs are registered.
- IDLE:
  - If req != 0, winner = first set bit scanning ptr, ptr+1, … modulo NREQ.
  - At that edge: owner=winner; capture the winner's three fields into arr_*; grant=onehot(winner); ack=onehot(winner) for one cycle; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: arr_start=1 for exactly one cycle; go to RUN.
- RUN:
  - On arr_done=1: req_done[owner]=1 for one cycle; grant=0; ptr=(owner+1) mod NREQ; go to RELEASE.
  - arr_busy is status only and does not gate transitions.
- RELEASE: one cycle, so the controller returns to its idle state; go to IDLE.
- Latency: req sampled at edge k → ack/grant visible after k; arr_start visible after k+1. Minimum job-to-job spacing is 4 cycles plus controller run time.
- Parameter stability: arr_* parameter outputs hold the captured values from ack until the next capture. Requester inputs are not sampled after ack; changing or dropping req mid-job has no effect.
- req dropped before being granted: no ack.
- Requester re-requests immediately after req_done: eligible, but lowest priority relative to the others.
- arr_done outside RUN: ignored.
- Parameter values are passed through unmodified; no range check. cycles=0 is legal.
- Simultaneous reset and arr_done: reset wins.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYCLES without arr_done: timeout_err=1 for one cycle, req_done[owner]=1, grant=0, ptr advances, go to RELEASE.
  - A later stray arr_done is ignored.
- Undefined: no counter; RUN waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Package systolic_arb_pkg:
  - state enum {IDLE, ISSUE, RUN, RELEASE}
  - width helper functions cw(SIZE), ww(SIZE)
- Sub-module rr_pick: combinational round-robin priority picker. Inputs req and ptr; outputs valid and index. Reusable by future memory-port arbiters.

Test Plan:
- Single job: NREQ=4, req=0010, cycles=5, wA=3, wB=4. Expect ack=0010 one cycle; arr_start one cycle later with arr_cycles_in=5, wA=3, wB=4. Model arr_done 20 cycles later → req_done=0010 next edge, grant=0, idle=1 two cycles after.
- Round-robin: req=1111 held and re-raised. Expect grant order 0,1,2,3,0. A requester never gets two consecutive grants while others wait.
- Parameter capture: change req_cycles[owner] from 5 to 9 one cycle after ack → arr_cycles_in stays 5 until the next grant.
- Reset mid-RUN: assert reset at cycle 10 of a job. Expect all outputs at reset values next edge, ptr=0. A following req=1000 is granted normally.
- Stray arr_done during IDLE and ISSUE → no req_done, no state change.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no arr_done → timeout_err and req_done[owner] at RUN cycle 16; the next requester is granted afterwards.
